// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit-counter width for a given word width; a counter never needs fewer than one bit.
    function automatic int piso_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake, serial output and control signals of the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             ser_en;
    logic             abort;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_data, load_valid, ser_en, abort,
        input  load_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  load_data, load_valid, ser_en, abort,
        output load_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter: async reset, synchronous clear (wins over enable), terminal count flag.
module piso_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = piso_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;

    // Count register: clear has priority, otherwise advance when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, stall, abort and gapless reload.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = piso_cnt_w(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus
);

    piso_state_t      state_r;
    piso_state_t      state_nxt_s;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_nxt_s;
    logic [CNT_W-1:0] cnt_s;
    logic             tc_s;
    logic             shifting_s;
    logic             ser_last_s;
    logic             word_end_s;
    logic             load_ready_s;
    logic             accept_s;
    logic             cnt_en_s;
    logic             cnt_clr_s;

    assign shifting_s   = (state_r == SHIFT);
    assign ser_last_s   = shifting_s && tc_s;
    assign word_end_s   = ser_last_s && bus.ser_en;
    // Abort and reset both mask the handshake so nothing is captured while flushing.
    assign load_ready_s = !reset && !bus.abort && ((state_r == IDLE) || word_end_s);
    assign accept_s     = bus.load_valid && load_ready_s;
    assign cnt_clr_s    = bus.abort || accept_s || word_end_s;
    assign cnt_en_s     = shifting_s && bus.ser_en && (cnt_s != CNT_W'(WIDTH - 1));

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en_s),
        .clr   (cnt_clr_s),
        .count (cnt_s),
        .tc    (tc_s)
    );

    // State and shift register update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            sr_r    <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            sr_r    <= sr_nxt_s;
        end
    end

    // Next-state and next shift-register contents.
    always_comb begin
        state_nxt_s = state_r;
        sr_nxt_s    = sr_r;
        if (bus.abort) begin
            state_nxt_s = IDLE;
            sr_nxt_s    = {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = SHIFT;
                        sr_nxt_s    = bus.load_data;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                SHIFT: begin
                    if (word_end_s) begin
                        if (accept_s) begin
                            state_nxt_s = SHIFT;
                            sr_nxt_s    = bus.load_data;
                        end else begin
                            state_nxt_s = IDLE;
                            sr_nxt_s    = {WIDTH{1'b0}};
                        end
                    end else if (bus.ser_en) begin
                        // Move the next bit toward whichever end drives ser_out.
                        if (MSB_FIRST) begin
                            sr_nxt_s = {sr_r[WIDTH-2:0], 1'b0};
                        end else begin
                            sr_nxt_s = {1'b0, sr_r[WIDTH-1:1]};
                        end
                    end else begin
                        sr_nxt_s = sr_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    sr_nxt_s    = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.load_ready = load_ready_s;
    assign bus.ser_out    = MSB_FIRST ? sr_r[WIDTH-1] : sr_r[0];
    assign bus.ser_valid  = shifting_s;
    assign bus.ser_last   = ser_last_s;
    assign bus.busy       = shifting_s;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: LSB-first and MSB-first 8-bit builds plus a 5-bit build, hand-computed bit streams.
module tb_piso_serializer;
    import piso_serializer_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [7:0]  seq_lsb;
    logic [7:0]  seq_msb;
    logic [15:0] seq_b2b;
    logic [11:0] en_pat;
    logic [7:0]  seq_a5;
    logic [4:0]  seq5;
    int          idx;

    piso_serializer_if #(.WIDTH(8)) ifa ();
    piso_serializer_if #(.WIDTH(8)) ifb ();
    piso_serializer_if #(.WIDTH(5)) ifc ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .reset(reset), .bus(ifa));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .reset(reset), .bus(ifb));
    piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b0)) dut_w5  (.clk(clk), .reset(reset), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        seq_lsb = 8'b0001_1110;              // 8'h1E LSB first: 0,1,1,1,1,0,0,0
        seq_msb = 8'b0111_1000;              // 8'h1E MSB first: 0,0,0,1,1,1,1,0
        seq_b2b = 16'b1111_0000_0001_1110;   // 8'h1E then 8'hF0, LSB first
        en_pat  = 12'b1011_1110_0011;        // stall three cycles on bit 2, one on bit 7
        seq_a5  = 8'b1010_0101;              // 8'hA5 LSB first: 1,0,1,0,0,1,0,1
        seq5    = 5'b10110;                  // 5'b10110 LSB first: 0,1,1,0,1

        reset = 1'b1;
        ifa.load_data = 8'h00; ifa.load_valid = 1'b0; ifa.ser_en = 1'b0; ifa.abort = 1'b0;
        ifb.load_data = 8'h00; ifb.load_valid = 1'b0; ifb.ser_en = 1'b0; ifb.abort = 1'b0;
        ifc.load_data = 5'h00; ifc.load_valid = 1'b0; ifc.ser_en = 1'b0; ifc.abort = 1'b0;

        // Reset values, and no handshake while reset is high.
        #2;
        chk("rst_ser_out",   32'(ifa.ser_out),   32'd0);
        chk("rst_ser_valid", 32'(ifa.ser_valid), 32'd0);
        chk("rst_ser_last",  32'(ifa.ser_last),  32'd0);
        chk("rst_busy",      32'(ifa.busy),      32'd0);
        ifa.load_valid = 1'b1;
        #1;
        chk("rst_load_ready", 32'(ifa.load_ready), 32'd0);
        ifa.load_valid = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;

        // LSB-first and MSB-first streams of 8'h1E side by side.
        ifa.load_data = 8'h1E; ifa.load_valid = 1'b1; ifa.ser_en = 1'b1;
        ifb.load_data = 8'h1E; ifb.load_valid = 1'b1; ifb.ser_en = 1'b1;
        #1;
        chk("t1_ready_idle", 32'(ifa.load_ready), 32'd1);
        tick;
        ifa.load_valid = 1'b0;
        ifb.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_out",   32'(ifa.ser_out),    32'(seq_lsb[i]));
            chk("t1_valid", 32'(ifa.ser_valid),  32'd1);
            chk("t1_busy",  32'(ifa.busy),       32'd1);
            chk("t1_last",  32'(ifa.ser_last),   32'(i == 7));
            chk("t1_ready", 32'(ifa.load_ready), 32'(i == 7));
            chk("t2_out",   32'(ifb.ser_out),    32'(seq_msb[i]));
            chk("t2_last",  32'(ifb.ser_last),   32'(i == 7));
            tick;
        end
        chk("t1_idle_valid", 32'(ifa.ser_valid), 32'd0);
        chk("t1_idle_busy",  32'(ifa.busy),      32'd0);
        chk("t2_idle_valid", 32'(ifb.ser_valid), 32'd0);

        // Back-to-back words with load_valid held: 16 contiguous valid bits.
        ifa.load_data = 8'h1E; ifa.load_valid = 1'b1;
        tick;
        ifa.load_data = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            chk("t3_out",   32'(ifa.ser_out),    32'(seq_b2b[i]));
            chk("t3_valid", 32'(ifa.ser_valid),  32'd1);
            chk("t3_last",  32'(ifa.ser_last),   32'((i == 7) || (i == 15)));
            chk("t3_ready", 32'(ifa.load_ready), 32'((i == 7) || (i == 15)));
            tick;
            if (i == 7) ifa.load_valid = 1'b0;
        end
        chk("t3_idle_valid", 32'(ifa.ser_valid), 32'd0);

        // Stall with ser_en low: bits held, no handshake while the last bit is stalled.
        ifa.load_data = 8'h1E; ifa.load_valid = 1'b1;
        tick;
        ifa.load_valid = 1'b0;
        idx = 0;
        for (int j = 0; j < 12; j++) begin
            ifa.ser_en = en_pat[j];
            #1;
            chk("t4_out",   32'(ifa.ser_out),    32'(seq_lsb[idx]));
            chk("t4_valid", 32'(ifa.ser_valid),  32'd1);
            chk("t4_last",  32'(ifa.ser_last),   32'(idx == 7));
            chk("t4_ready", 32'(ifa.load_ready), 32'((idx == 7) && en_pat[j]));
            tick;
            if (en_pat[j]) idx++;
        end
        ifa.ser_en = 1'b1;
        chk("t4_idle_valid", 32'(ifa.ser_valid), 32'd0);

        // Abort at bit 4 while a new word is offered.
        ifa.load_data = 8'h1E; ifa.load_valid = 1'b1;
        tick;
        ifa.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        chk("t5_bit4", 32'(ifa.ser_out), 32'd1);
        ifa.abort = 1'b1; ifa.load_valid = 1'b1; ifa.load_data = 8'hA5;
        #1;
        chk("t5_ready_abort", 32'(ifa.load_ready), 32'd0);
        tick;
        ifa.abort = 1'b0;
        chk("t5_valid", 32'(ifa.ser_valid), 32'd0);
        chk("t5_busy",  32'(ifa.busy),      32'd0);
        chk("t5_last",  32'(ifa.ser_last),  32'd0);
        chk("t5_out",   32'(ifa.ser_out),   32'd0);
        #1;
        chk("t5_ready_after", 32'(ifa.load_ready), 32'd1);
        tick;
        ifa.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t5_new_out",  32'(ifa.ser_out),  32'(seq_a5[i]));
            chk("t5_new_last", 32'(ifa.ser_last), 32'(i == 7));
            tick;
        end
        chk("t5_idle_valid", 32'(ifa.ser_valid), 32'd0);

        // 5-bit build: asynchronous reset mid-word, then a fresh word.
        ifc.load_data = 5'b11011; ifc.load_valid = 1'b1; ifc.ser_en = 1'b1;
        tick;
        ifc.load_valid = 1'b0;
        tick;
        tick;
        chk("t6_busy_pre", 32'(ifc.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_out",   32'(ifc.ser_out),    32'd0);
        chk("t6_rst_valid", 32'(ifc.ser_valid),  32'd0);
        chk("t6_rst_last",  32'(ifc.ser_last),   32'd0);
        chk("t6_rst_busy",  32'(ifc.busy),       32'd0);
        chk("t6_rst_ready", 32'(ifc.load_ready), 32'd0);
        tick;
        reset = 1'b0;
        ifc.load_data = 5'b10110; ifc.load_valid = 1'b1;
        #1;
        chk("t6_ready", 32'(ifc.load_ready), 32'd1);
        tick;
        ifc.load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t6_out",   32'(ifc.ser_out),   32'(seq5[i]));
            chk("t6_valid", 32'(ifc.ser_valid), 32'd1);
            chk("t6_last",  32'(ifc.ser_last),  32'(i == 4));
            tick;
        end
        chk("t6_idle_valid", 32'(ifc.ser_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
